// File: rtl/sram_ctrl_23.sv
// rtl/sram_ctrl_23.sv - single-port SRAM controller with in-order 4-deep read response FIFO
// SRAM_CTRL_INIT_EN: when defined, INIT zero-fills words 0..DEPTH-1 before RUN.
module sram_ctrl_23 #(
  parameter int DEPTH = 65536,
  parameter int AW    = 16,
  parameter int DW    = 23
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          init_done,
  output logic          cs_en,
  output logic          wr_en,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wr_data,
  input  logic [DW-1:0] rd_data
);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state, state_nxt;
  logic          accept, push, pop, last_init;
  logic          s1_rd, s2_rd;
  logic [2:0]    count;
  logic [1:0]    wptr, rptr;
  logic [DW-1:0] fifo_mem [4];

  assign accept = req_valid && req_ready;
  assign push   = s2_rd;
  assign pop    = rsp_valid && rsp_ready;

`ifdef SRAM_CTRL_INIT_EN
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  // The last sweep write is on the bus; it completes on the edge that enters RUN.
  assign last_init = cs_en && (addr == LAST_ADDR);
`else
  logic unused_depth;
  assign unused_depth = (DEPTH > 0);
  assign last_init    = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && last_init) state_nxt = RUN;
  end

  // Queued responses plus reads still in the SRAM pipeline must fit in the FIFO.
  always_comb begin
    req_ready = 1'b0;
    init_done = 1'b0;
    if (state == RUN) begin
      init_done = 1'b1;
      req_ready = (count + {2'b00, s1_rd} + {2'b00, s2_rd}) < 3'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_en   <= 1'b0;
      wr_en   <= 1'b0;
      addr    <= '0;
      wr_data <= '0;
      s1_rd   <= 1'b0;
      s2_rd   <= 1'b0;
    end else begin
      s2_rd <= s1_rd;
      s1_rd <= 1'b0;
      if (state == INIT) begin
`ifdef SRAM_CTRL_INIT_EN
        if (last_init) begin
          cs_en <= 1'b0;
          wr_en <= 1'b0;
        end else begin
          cs_en   <= 1'b1;
          wr_en   <= 1'b1;
          wr_data <= '0;
          addr    <= cs_en ? addr + AW'(1) : '0;
        end
`else
        cs_en <= 1'b0;
        wr_en <= 1'b0;
`endif
      end else begin
        cs_en <= accept;
        wr_en <= accept && req_wr;
        s1_rd <= accept && !req_wr;
        if (accept) begin
          addr    <= req_addr;
          wr_data <= req_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 2'd1;
      if (pop)  rptr <= rptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= rd_data;
  end

  assign rsp_valid = (count != 3'd0);
  assign rsp_data  = rsp_valid ? fifo_mem[rptr] : '0;

endmodule

// File: tb/tb_sram_ctrl_23.sv
// tb/tb_sram_ctrl_23.sv - scoreboard bench for sram_ctrl_23 with a behavioural SRAM
// Honours SRAM_CTRL_INIT_EN the same way as the design.
module tb_sram_ctrl_23;
  localparam int AW = 16;
  localparam int DW = 23;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid, req_ready, req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          init_done, cs_en, wr_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data, rd_data;

  logic [DW-1:0] sram [0:65535];
  logic [DW-1:0] rd_q = '0;
  logic [DW-1:0] sb [$];
  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int first_cyc = 0;

  sram_ctrl_23 #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .init_done(init_done), .cs_en(cs_en), .wr_en(wr_en), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cs_en) begin
      if (wr_en) sram[addr] <= wr_data;
      else       rd_q <= sram[addr];
    end
  end
  assign rd_data = rd_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL rsp_unexpected: got %0h expected no response", rsp_data);
      end else begin
        chk("rsp_data", 64'(rsp_data), 64'(sb.pop_front()));
      end
    end
  end

  // For reads, d carries the hand-computed expected response.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) chk("req_accept_timeout", 64'(req_ready), 64'd1);
    else begin
      if (!wr) sb.push_back(d);
      accept_cyc = cyc;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic post_reset();
`ifdef SRAM_CTRL_INIT_EN
    for (int k = 0; k < DEPTH; k++) begin
      @(posedge clk);
      #1;
      chk("init_strobe", 64'({cs_en, wr_en, init_done, req_ready, wr_data, addr}),
          64'({1'b1, 1'b1, 1'b0, 1'b0, 23'd0, 16'(k)}));
    end
    @(posedge clk);
    #1;
    chk("init_done", 64'({init_done, req_ready, cs_en}), 64'(3'b110));
`else
    chk("pre_edge_init_done", 64'(init_done), 64'd0);
    @(posedge clk);
    #1;
    chk("run_entry", 64'({init_done, req_ready, cs_en}), 64'(3'b110));
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("no_init_write", 64'(cs_en), 64'd0);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", 64'({cs_en, wr_en, req_ready, rsp_valid, init_done}), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_wdata", 64'(wr_data), 64'd0);
    chk("rst_rdata", 64'(rsp_data), 64'd0);
    rst = 1'b0;
    post_reset();

`ifdef SRAM_CTRL_INIT_EN
    issue(1'b0, 16'd5, 23'd0);
    drain();
`endif

    issue(1'b1, 16'hFFFF, 23'h7FFFFF);
    issue(1'b0, 16'hFFFF, 23'h7FFFFF);
    chk("lat_t1", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_t2", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_t3", 64'({rsp_valid, rsp_data}), 64'({1'b1, 23'h7FFFFF}));
    drain();

    issue(1'b1, 16'd3, 23'h123456);
    issue(1'b1, 16'h0010, 23'h2AAAAA);
    issue(1'b1, 16'd3, 23'h055555);
    issue(1'b0, 16'h0010, 23'h2AAAAA);
    issue(1'b0, 16'd3, 23'h055555);
    drain();

    for (int i = 0; i < 6; i++) issue(1'b1, 16'(16'h20 + i), 23'(23'h100 + i));
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(1'b0, 16'(16'h20 + i), 23'(23'h100 + i));
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 16'h24;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("bp_hold", 64'({req_ready, rsp_valid, rsp_data}), 64'({1'b0, 1'b1, 23'h100}));
    end
    rsp_ready = 1'b1;
    issue(1'b0, 16'h24, 23'h104);
    issue(1'b0, 16'h25, 23'h105);
    drain();

    for (int i = 0; i < 100; i++) issue(1'b1, 16'(16'h200 + i), 23'(i * 3 + 7));
    for (int i = 0; i < 100; i++) begin
      issue(1'b0, 16'(16'h200 + i), 23'(i * 3 + 7));
      if (i == 0) first_cyc = accept_cyc;
    end
    chk("stream_span", 64'(accept_cyc - first_cyc), 64'd99);
    drain();

    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(1'b0, 16'(16'h200 + i), 23'(i * 3 + 7));
    @(posedge clk);
    #1;
    chk("pre_rst_queued", 64'({req_ready, rsp_valid, rsp_data}), 64'({1'b0, 1'b1, 23'd7}));
    rst = 1'b1;
    sb.delete();
    #1;
    chk("rst_async", 64'({rsp_valid, cs_en, req_ready, init_done, rsp_data}), 64'd0);
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    post_reset();
    chk("no_stale", 64'(rsp_valid), 64'd0);

    issue(1'b0, 16'hFFFF, 23'h7FFFFF);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_ctrl_23.md
SRAM_CTRL_23 -- requirements
Module: sram_ctrl_23

Interface
REQ-001 SHALL have parameter DEPTH, default 65536, number of SRAM words.
REQ-002 SHALL have parameter AW, default 16, address width.
REQ-003 SHALL have parameter DW, default 23, data width.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  input  1  host request valid.
REQ-007 SHALL have port req_ready  output  1  controller accepts request this cycle.
REQ-008 SHALL have port req_wr  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  AW  request address.
REQ-010 SHALL have port req_wdata  input  DW  write data.
REQ-011 SHALL have port rsp_valid  output  1  read response valid.
REQ-012 SHALL have port rsp_ready  input  1  host accepts response.
REQ-013 SHALL have port rsp_data  output  DW  read response data.
REQ-014 SHALL have port init_done  output  1  memory initialised, controller in RUN.
REQ-015 SHALL have ports cs_en, wr_en (output, 1), addr (output, AW), wr_data (output, DW) driving the SRAM; all four registered.
REQ-016 SHALL have port rd_data  input  DW  SRAM read data, valid the cycle after a read strobe.

Function
REQ-017 SHALL implement FSM states INIT and RUN; INIT -> RUN after the last init write; RUN is terminal until reset.
REQ-018 In INIT SHALL drive cs_en=1, wr_en=1, wr_data=0, addr counting 0..DEPTH-1, one word per cycle, with req_ready=0.
REQ-019 init_done SHALL be 1 exactly while in RUN.
REQ-020 A request SHALL be accepted on a cycle with req_valid=1 and req_ready=1; the SRAM strobe for it SHALL be on the next cycle (cs_en=1, wr_en=req_wr, addr, wr_data captured).
REQ-021 With no accepted request, cs_en SHALL be 0 the following cycle.
REQ-022 Read data SHALL be captured from rd_data the cycle after the read strobe into a 4-entry in-order response FIFO; rsp_valid SHALL rise no earlier than 3 cycles after acceptance (accept t, strobe t+1, capture t+2, rsp_valid from t+3).
REQ-023 req_ready SHALL be 1 in RUN only when FIFO count + reads in flight (accepted, not yet captured) < 4; never depends on req_valid; writes and reads gated identically.
REQ-024 Response FIFO SHALL pop on rsp_valid=1 and rsp_ready=1; rsp_data/rsp_valid SHALL be stable while rsp_valid=1 and rsp_ready=0.
REQ-025 Simultaneous FIFO push and pop SHALL keep count unchanged, including at count 4 and count 0.
REQ-026 With rsp_ready held 1, back-to-back reads SHALL sustain one accept per cycle.
REQ-027 Write responses SHALL NOT be generated; a read after a write to the same address SHALL return the new data.
REQ-028 Address counter and FIFO pointers SHALL wrap modulo their size without error.

Reset
REQ-029 On rst=1 SHALL immediately force: state INIT (or RUN, per REQ-033), cs_en=0, wr_en=0, addr=0, wr_data=0, req_ready=0, rsp_valid=0, rsp_data=0, init_done=0, FIFO empty, in-flight cleared.
REQ-030 Reset asserted mid-operation SHALL discard all outstanding reads and queued responses; init restarts from address 0.
REQ-031 First SRAM strobe after reset release SHALL occur no earlier than the first rising edge following release.

Configuration
REQ-032 Macro SRAM_CTRL_INIT_EN defined: INIT zero-fill per REQ-018, DEPTH cycles.
REQ-033 Macro SRAM_CTRL_INIT_EN undefined: no INIT sweep; FSM enters RUN on the first edge after reset release, init_done=1 from then, memory contents undefined.

Verification
REQ-034 Init (macro on, DEPTH=16): release reset -> 16 cycles cs_en=wr_en=1, addr 0..15, wr_data=0; init_done=1 after; a read of addr 5 returns 0.
REQ-035 Write 0x7FFFFF to addr 0xFFFF then read 0xFFFF -> rsp_data=0x7FFFFF, rsp_valid 3 cycles after read acceptance.
REQ-036 Hold rsp_ready=0, issue 6 reads -> exactly 4 accepted, req_ready=0 thereafter; release rsp_ready -> responses in order, remaining 2 accepted.
REQ-037 Streaming 100 reads with rsp_ready=1 -> 100 accepts in 100 consecutive cycles, responses in address order.
REQ-038 Assert rst with 3 responses queued and 1 read in flight -> rsp_valid=0 immediately, no stale response after release, init restarts at addr 0.
REQ-039 Macro off -> init_done=1 one cycle after reset release, req_ready=1, no init writes.
